ram_port_bridge: RTL and testbench

Parametrised bridge that carries WORD_W-bit read and write requests from cache control onto a single shared narrow RAM port of RAM_W bits. Each word is split into WORD_W/RAM_W beats, transferred lowest beat first. Unlike the earlier separate read and write address paths, the RAM sees one address bus. A request that arrives while the bridge is busy is queued, not lost. The block sits between cache control and the external RAM model.

---
 rtl/ram_port_bridge_pkg.sv | 24 ++
 rtl/ram_port_bridge_if.sv | 32 +++
 rtl/ram_port_bridge_arb.sv | 29 ++
 rtl/ram_port_bridge.sv | 160 ++++++++++++++++
 tb/tb_ram_port_bridge.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/ram_port_bridge_pkg.sv
// rtl/ram_port_bridge_pkg.sv - shared types and parameter check for ram_port_bridge
package ram_port_bridge_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD_BEAT = 3'd1,
    ST_WR_BEAT = 3'd2,
    ST_RD_DONE = 3'd3,
    ST_WR_DONE = 3'd4
  } bridge_state_t;

  typedef enum logic {
    OP_RD = 1'b0,
    OP_WR = 1'b1
  } op_t;

  // A word must split into 1..16 whole RAM beats
  function automatic bit bridge_ratio_ok(input int word_w, input int ram_w);
    if (ram_w <= 0) return 1'b0;
    if ((word_w % ram_w) != 0) return 1'b0;
    return ((word_w / ram_w) >= 1) && ((word_w / ram_w) <= 16);
  endfunction

endpackage

// File: rtl/ram_port_bridge_if.sv
// rtl/ram_port_bridge_if.sv - cache-side request bus and shared RAM port bundle
interface ram_port_bridge_if #(
  parameter int WORD_W = 32,
  parameter int RAM_W  = 16,
  parameter int ADDR_W = 32
);
  logic              rd_start;
  logic [ADDR_W-1:0] rd_addr_base;
  logic [WORD_W-1:0] rd_data_out;
  logic              rd_done;
  logic              wr_start;
  logic [ADDR_W-1:0] wr_addr_base;
  logic [WORD_W-1:0] wr_data_in;
  logic              wr_done;
  logic              busy;
  logic [ADDR_W-1:0] ram_addr;
  logic [RAM_W-1:0]  ram_wr_data;
  logic              ram_wr_en;
  logic [RAM_W-1:0]  ram_rd_data;

  // Cache control plus RAM model side
  modport master (
    output rd_start, rd_addr_base, wr_start, wr_addr_base, wr_data_in, ram_rd_data,
    input  rd_data_out, rd_done, wr_done, busy, ram_addr, ram_wr_data, ram_wr_en
  );

  // Bridge side
  modport slave (
    input  rd_start, rd_addr_base, wr_start, wr_addr_base, wr_data_in, ram_rd_data,
    output rd_data_out, rd_done, wr_done, busy, ram_addr, ram_wr_data, ram_wr_en
  );
endinterface

// File: rtl/ram_port_bridge_arb.sv
// rtl/ram_port_bridge_arb.sv - read/write arbiter; RAM_PORT_BRIDGE_RR_ARB_EN selects round-robin ties
module ram_port_bridge_arb
  import ram_port_bridge_pkg::*;
(
  input  logic rd_pend,
  input  logic wr_pend,
  input  op_t  last_op,
  output op_t  grant
);

`ifdef RAM_PORT_BRIDGE_RR_ARB_EN
  // A tie goes to the kind that lost the previous tie (last_op = previous tie winner)
  always_comb begin
    grant = OP_RD;
    if (wr_pend && rd_pend) grant = (last_op == OP_WR) ? OP_RD : OP_WR;
    else if (wr_pend)       grant = OP_WR;
  end
`else
  // Fixed priority: a pending write always wins
  always_comb begin
    grant = OP_RD;
    if (wr_pend) grant = OP_WR;
  end

  logic unused_last_op;
  assign unused_last_op = last_op;
`endif

endmodule

// File: rtl/ram_port_bridge.sv
// rtl/ram_port_bridge.sv - splits word reads/writes into beats on one narrow RAM port; macro RAM_PORT_BRIDGE_RR_ARB_EN
module ram_port_bridge #(
  parameter int WORD_W = 32,
  parameter int RAM_W  = 16,
  parameter int ADDR_W = 32
) (
  input logic              clk,
  input logic              reset_n,
  ram_port_bridge_if.slave bus
);
  import ram_port_bridge_pkg::*;

  localparam int              BEATS     = WORD_W / RAM_W;
  localparam int              CNT_W     = 4;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  if (!bridge_ratio_ok(WORD_W, RAM_W)) begin : g_bad_ratio
    $fatal(1, "ram_port_bridge: WORD_W must be 1..16 whole multiples of RAM_W");
  end

  bridge_state_t     state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              rd_pend_q, rd_pend_d;
  logic              wr_pend_q, wr_pend_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [WORD_W-1:0] wr_data_q, wr_data_d;
  logic [WORD_W-1:0] asm_q, asm_d;
  logic [WORD_W-1:0] rd_data_q, rd_data_d;

  logic              rd_req, wr_req;
  logic              in_beat;
  logic [ADDR_W-1:0] beat_addr;
  op_t               last_op, grant;

  // A start pulse in IDLE is served the same cycle it arrives
  assign rd_req = rd_pend_q | bus.rd_start;
  assign wr_req = wr_pend_q | bus.wr_start;

  ram_port_bridge_arb u_arb (
    .rd_pend (rd_req),
    .wr_pend (wr_req),
    .last_op (last_op),
    .grant   (grant)
  );

`ifdef RAM_PORT_BRIDGE_RR_ARB_EN
  op_t last_op_q, last_op_d;

  assign last_op_d = (state_q == ST_IDLE && rd_req && wr_req) ? grant : last_op_q;
  assign last_op   = last_op_q;

  // Remember the winner of the most recent tie; reset value lets write win the first tie
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) last_op_q <= OP_RD;
    else          last_op_q <= last_op_d;
  end
`else
  assign last_op = OP_RD;
`endif

  assign in_beat   = (state_q == ST_RD_BEAT) || (state_q == ST_WR_BEAT);
  assign beat_addr = ((state_q == ST_WR_BEAT) ? wr_addr_q : rd_addr_q) + ADDR_W'(cnt_q);

  // Next state, request capture and beat sequencing
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rd_pend_d  = rd_pend_q;
    wr_pend_d  = wr_pend_q;
    rd_addr_d  = rd_addr_q;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    ram_addr_d = ram_addr_q;
    asm_d      = asm_q;
    rd_data_d  = rd_data_q;

    if (bus.rd_start) begin
      rd_pend_d = 1'b1;
      rd_addr_d = bus.rd_addr_base;
    end
    if (bus.wr_start) begin
      wr_pend_d = 1'b1;
      wr_addr_d = bus.wr_addr_base;
      wr_data_d = bus.wr_data_in;
    end

    case (state_q)
      ST_IDLE: begin
        if (rd_req || wr_req) begin
          cnt_d = '0;
          if (grant == OP_WR) begin
            state_d   = ST_WR_BEAT;
            wr_pend_d = 1'b0;
          end else begin
            state_d   = ST_RD_BEAT;
            rd_pend_d = 1'b0;
          end
        end
      end
      ST_RD_BEAT: begin
        asm_d                    = asm_q >> RAM_W;
        asm_d[WORD_W-1 -: RAM_W] = bus.ram_rd_data;
        ram_addr_d               = beat_addr;
        if (cnt_q == LAST_BEAT) state_d = ST_RD_DONE;
        else                    cnt_d   = cnt_q + 1'b1;
      end
      ST_WR_BEAT: begin
        ram_addr_d = beat_addr;
        if (cnt_q == LAST_BEAT) state_d = ST_WR_DONE;
        else                    cnt_d   = cnt_q + 1'b1;
      end
      ST_RD_DONE: begin
        rd_data_d = asm_q;
        state_d   = ST_IDLE;
      end
      ST_WR_DONE: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      rd_pend_q  <= 1'b0;
      wr_pend_q  <= 1'b0;
      rd_addr_q  <= '0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      ram_addr_q <= '0;
      asm_q      <= '0;
      rd_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rd_pend_q  <= rd_pend_d;
      wr_pend_q  <= wr_pend_d;
      rd_addr_q  <= rd_addr_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      ram_addr_q <= ram_addr_d;
      asm_q      <= asm_d;
      rd_data_q  <= rd_data_d;
    end
  end

  // Outputs decode straight from registers so reset clears them at once;
  // the assembled word is shown during RD_DONE, then held in rd_data_q
  assign bus.ram_addr    = in_beat ? beat_addr : ram_addr_q;
  assign bus.ram_wr_en   = (state_q == ST_WR_BEAT);
  assign bus.ram_wr_data = bus.ram_wr_en ? RAM_W'(wr_data_q >> (RAM_W * int'(cnt_q))) : '0;
  assign bus.rd_done     = (state_q == ST_RD_DONE);
  assign bus.wr_done     = (state_q == ST_WR_DONE);
  assign bus.rd_data_out = (state_q == ST_RD_DONE) ? asm_q : rd_data_q;
  assign bus.busy        = (state_q != ST_IDLE) || rd_pend_q || wr_pend_q;

endmodule

// File: tb/tb_ram_port_bridge.sv
// tb/tb_ram_port_bridge.sv - directed self-checking bench for ram_port_bridge
module tb_ram_port_bridge;

  logic        clk = 1'b0;
  logic        reset_n;
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] prev_rd;

  always #5 clk = ~clk;

  ram_port_bridge_if #(.WORD_W(32), .RAM_W(16), .ADDR_W(32)) b32 ();
  ram_port_bridge_if #(.WORD_W(64), .RAM_W(16), .ADDR_W(32)) b64 ();

  ram_port_bridge #(.WORD_W(32), .RAM_W(16), .ADDR_W(32)) u_dut32 (
    .clk(clk), .reset_n(reset_n), .bus(b32)
  );
  ram_port_bridge #(.WORD_W(64), .RAM_W(16), .ADDR_W(32)) u_dut64 (
    .clk(clk), .reset_n(reset_n), .bus(b64)
  );

  // RAM model: preloaded contents until a location is written
  logic [15:0] mem    [0:1023];
  bit          wvalid [0:1023];

  function automatic logic [15:0] init_val(input logic [31:0] a);
    case (a)
      32'h200: return 16'h5678;
      32'h201: return 16'h1234;
      32'h300: return 16'hAAAA;
      32'h301: return 16'h5555;
      default: return 16'h0000;
    endcase
  endfunction

  always @(posedge clk) begin
    if (b32.ram_wr_en) begin
      mem[b32.ram_addr[9:0]]    <= b32.ram_wr_data;
      wvalid[b32.ram_addr[9:0]] <= 1'b1;
    end
  end

  assign b32.ram_rd_data = wvalid[b32.ram_addr[9:0]] ? mem[b32.ram_addr[9:0]] : init_val(b32.ram_addr);
  assign b64.ram_rd_data = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // w_at/r_at: cycle of the start pulse (-1 none); w0/r0: expected first beat cycle (0 none)
  typedef struct {
    int          w_at;
    int          r_at;
    logic [31:0] waddr;
    logic [31:0] wdata;
    logic [31:0] raddr;
    int          w0;
    int          r0;
    logic [31:0] rexp;
  } vec_t;

  vec_t vecs [9];

  // Entered and left just after a rising edge; cycle 0 is the cycle of the first pulse
  task automatic run_seq(input vec_t v, input int idx);
    int          last;
    logic [31:0] hold, slice, exp_rd;
    bit          in_wb, in_rb;
    last = (v.w0 > v.r0) ? v.w0 : v.r0;
    hold = (v.w0 > v.r0) ? v.waddr + 32'd1 : v.raddr + 32'd1;
    b32.wr_addr_base = v.waddr;
    b32.wr_data_in   = v.wdata;
    b32.rd_addr_base = v.raddr;
    for (int c = 0; c <= last + 3; c++) begin
      b32.wr_start = (c == v.w_at);
      b32.rd_start = (c == v.r_at);
      if (c > 0) begin
        @(negedge clk);
        in_wb = (v.w0 > 0) && (c >= v.w0) && (c < v.w0 + 2);
        in_rb = (v.r0 > 0) && (c >= v.r0) && (c < v.r0 + 2);
        check($sformatf("v%0d c%0d ram_wr_en", idx, c), 64'(b32.ram_wr_en), 64'(in_wb));
        if (in_wb) begin
          slice = v.wdata >> (16 * (c - v.w0));
          check($sformatf("v%0d c%0d wr ram_addr", idx, c), 64'(b32.ram_addr), 64'(v.waddr + 32'(c - v.w0)));
          check($sformatf("v%0d c%0d ram_wr_data", idx, c), 64'(b32.ram_wr_data), 64'(slice[15:0]));
        end else begin
          check($sformatf("v%0d c%0d ram_wr_data idle", idx, c), 64'(b32.ram_wr_data), 64'h0);
        end
        if (in_rb)
          check($sformatf("v%0d c%0d rd ram_addr", idx, c), 64'(b32.ram_addr), 64'(v.raddr + 32'(c - v.r0)));
        check($sformatf("v%0d c%0d wr_done", idx, c), 64'(b32.wr_done), 64'((v.w0 > 0) && (c == v.w0 + 2)));
        check($sformatf("v%0d c%0d rd_done", idx, c), 64'(b32.rd_done), 64'((v.r0 > 0) && (c == v.r0 + 2)));
        exp_rd = ((v.r0 > 0) && (c >= v.r0 + 2)) ? v.rexp : prev_rd;
        check($sformatf("v%0d c%0d rd_data_out", idx, c), 64'(b32.rd_data_out), 64'(exp_rd));
        check($sformatf("v%0d c%0d busy", idx, c), 64'(b32.busy), 64'(c <= last + 2));
        if (c == last + 2)
          check($sformatf("v%0d c%0d ram_addr hold", idx, c), 64'(b32.ram_addr), 64'(hold));
      end
      @(posedge clk); #1;
    end
    b32.wr_start = 1'b0;
    b32.rd_start = 1'b0;
    if (v.r0 > 0) prev_rd = v.rexp;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish, required finish before 100000");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] w64, s64;
    logic [31:0] a64;

    vecs[0] = '{0, -1, 32'h100, 32'hDEADBEEF, 32'h0, 1, 0, 32'h0};
    vecs[1] = '{-1, 0, 32'h0, 32'h0, 32'h200, 0, 1, 32'h12345678};
    vecs[2] = '{-1, 0, 32'h0, 32'h0, 32'h100, 0, 1, 32'hDEADBEEF};
    vecs[3] = '{0, -1, 32'h3FE, 32'hCAFEF00D, 32'h0, 1, 0, 32'h0};
    vecs[4] = '{-1, 0, 32'h0, 32'h0, 32'h3FE, 0, 1, 32'hCAFEF00D};
    vecs[5] = '{0, 0, 32'h120, 32'h11112222, 32'h200, 1, 5, 32'h12345678};
    vecs[6] = '{0, 1, 32'h140, 32'h0BADC0DE, 32'h300, 1, 5, 32'h5555AAAA};
    vecs[7] = '{2, 0, 32'h150, 32'hFEEDFACE, 32'h120, 5, 1, 32'h11112222};
`ifdef RAM_PORT_BRIDGE_RR_ARB_EN
    vecs[8] = '{0, 0, 32'h130, 32'h33334444, 32'h300, 5, 1, 32'h5555AAAA};
`else
    vecs[8] = '{0, 0, 32'h130, 32'h33334444, 32'h300, 1, 5, 32'h5555AAAA};
`endif

    reset_n = 1'b0;
    b32.rd_start = 1'b0; b32.wr_start = 1'b0;
    b32.rd_addr_base = '0; b32.wr_addr_base = '0; b32.wr_data_in = '0;
    b64.rd_start = 1'b0; b64.wr_start = 1'b0;
    b64.rd_addr_base = '0; b64.wr_addr_base = '0; b64.wr_data_in = '0;
    prev_rd = '0;
    #2;
    check("reset rd_data_out", 64'(b32.rd_data_out), 64'h0);
    check("reset rd_done", 64'(b32.rd_done), 64'h0);
    check("reset wr_done", 64'(b32.wr_done), 64'h0);
    check("reset busy", 64'(b32.busy), 64'h0);
    check("reset ram_addr", 64'(b32.ram_addr), 64'h0);
    check("reset ram_wr_en", 64'(b32.ram_wr_en), 64'h0);
    check("reset ram_wr_data", 64'(b32.ram_wr_data), 64'h0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 9; i++) run_seq(vecs[i], i);

    // 64-bit word, four beats wrapping past the top of the address space
    w64 = 64'h0123456789ABCDEF;
    b64.wr_addr_base = 32'hFFFFFFFE;
    b64.wr_data_in   = w64;
    b64.wr_start     = 1'b1;
    @(posedge clk); #1;
    b64.wr_start = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      check($sformatf("w64 c%0d ram_wr_en", c), 64'(b64.ram_wr_en), 64'(c <= 4));
      if (c <= 4) begin
        a64 = 32'hFFFFFFFE + 32'(c - 1);
        s64 = w64 >> (16 * (c - 1));
        check($sformatf("w64 c%0d ram_addr", c), 64'(b64.ram_addr), 64'(a64));
        check($sformatf("w64 c%0d ram_wr_data", c), 64'(b64.ram_wr_data), 64'(s64[15:0]));
      end
      check($sformatf("w64 c%0d wr_done", c), 64'(b64.wr_done), 64'(c == 5));
      if (c == 5) check("w64 ram_addr hold", 64'(b64.ram_addr), 64'h1);
      @(posedge clk); #1;
    end

    // Reset asserted during beat 1 of a read
    b32.rd_addr_base = 32'h200;
    b32.rd_start     = 1'b1;
    @(posedge clk); #1;
    b32.rd_start = 1'b0;
    @(posedge clk); #1;
    check("pre-reset ram_addr beat1", 64'(b32.ram_addr), 64'h201);
    reset_n = 1'b0;
    #1;
    check("midreset ram_addr", 64'(b32.ram_addr), 64'h0);
    check("midreset rd_data_out", 64'(b32.rd_data_out), 64'h0);
    check("midreset busy", 64'(b32.busy), 64'h0);
    check("midreset rd_done", 64'(b32.rd_done), 64'h0);
    check("midreset ram_wr_en", 64'(b32.ram_wr_en), 64'h0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check($sformatf("postreset c%0d rd_done", c), 64'(b32.rd_done), 64'h0);
      check($sformatf("postreset c%0d busy", c), 64'(b32.busy), 64'h0);
      @(posedge clk); #1;
    end
    prev_rd = '0;
    run_seq('{-1, 0, 32'h0, 32'h0, 32'h200, 0, 1, 32'h12345678}, 9);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
